bit_serial_addsub: RTL and testbench
====================================

BIT_SERIAL_ADDSUB -- requirements
Module: bit_serial_addsub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 Port: a  input  WIDTH  minuend/addend; sampled with start.
REQ-007 Port: b  input  WIDTH  subtrahend/addend; sampled with start.
REQ-008 Port: busy  output  1  high while an operation is in progress (RUN state).
REQ-009 Port: done  output  1  single-cycle completion pulse.
REQ-010 Port: result  output  WIDTH  difference/sum of the last completed operation.
REQ-011 Port: cbout  output  1  carry-out (add) or borrow-out (sub) of the last completed operation.
REQ-012 Port: ovf  output  1  two's-complement signed overflow of the last completed operation.

Function
REQ-013 FSM states IDLE, RUN, DONE shall be used; IDLE is the reset state.
REQ-014 In IDLE with start=1, the block shall capture a, b and mode, clear the carry/borrow flip-flop to 0 and the bit index to 0, and enter RUN.
REQ-015 In RUN, the block shall process one bit per cycle, LSB first, using bit index i = 0..WIDTH-1.
REQ-016 Add-mode bit i: s = a[i]^b[i]^c; c_next = majority(a[i], b[i], c).
REQ-017 Sub-mode bit i: d = a[i]^b[i]^bw; bw_next = (~a[i]&b[i]) | (~(a[i]^b[i])&bw).
REQ-018 Each bit result shall be written into an internal shift register; result/cbout/ovf ports shall not change during RUN.
REQ-019 When i = WIDTH-1 is processed, the FSM shall enter DONE, and on that same edge:
  - result shall be loaded from the completed shift register;
  - cbout shall be loaded from c_next or bw_next;
  - ovf shall be loaded as (carry/borrow into MSB) XOR (carry/borrow out of MSB).
REQ-020 Latency: with the capture edge as edge 0, bit i shall be processed at edge i+1, and done shall be high for exactly the cycle following edge WIDTH.
REQ-021 DONE shall return to IDLE unconditionally on the next edge; done=1 only in DONE.
REQ-022 busy shall be 1 exactly while in RUN (WIDTH cycles).
REQ-023 start shall be ignored in RUN and DONE; captured operands shall not be affected by a, b or mode changes after the capture edge.
REQ-024 After DONE, a start in the following IDLE cycle shall be accepted, giving a minimum issue interval of WIDTH+2 cycles.
REQ-025 result, cbout and ovf shall hold their values until the next DONE entry or reset.

Reset
REQ-026 With rst_n=0 at a rising edge, the block shall enter IDLE with busy=0, done=0, result=0, cbout=0, ovf=0, and internal index, shift register and carry/borrow cleared.
REQ-027 Reset shall take priority over start and over any RUN/DONE activity; an operation interrupted by reset shall produce no done pulse.
REQ-028 While rst_n=0, start shall be ignored.

Verification (WIDTH=8)
REQ-029 Add: mode=0, a=0x5A, b=0x33 -> done exactly 8 edges after the capture edge; result=0x8D, cbout=0, ovf=1; busy high for 8 cycles.
REQ-030 Sub: mode=1, a=0x10, b=0x20 -> result=0xF0, cbout=1, ovf=0.
REQ-031 Wrap and signed edge cases:
  - add 0xFF+0x01 -> result=0x00, cbout=1, ovf=0;
  - sub 0x80-0x01 -> result=0x7F, cbout=0, ovf=1.
REQ-032 Ignored start: start a=0x01, b=0x01 (add); pulse start with a=0xF0 mid-RUN and again in DONE -> single done, result=0x02; start one cycle after DONE is accepted.
REQ-033 Reset mid-operation: rst_n=0 at bit 3 of a RUN -> next cycle busy=0, done=0, result=0, and no done pulse follows.
REQ-034 Operand stability: change a, b and mode every cycle during RUN -> result matches the operands captured at start.

Source files
------------

// File: rtl/bit_serial_addsub_if.sv
// bit_serial_addsub_if: request/response bundle for the bit-serial adder/subtractor.
//   master drives start, mode, a, b; slave drives busy, done, result, cbout, ovf.
interface bit_serial_addsub_if #(parameter int WIDTH = 8);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cbout;
    logic             ovf;
    modport master (output start, mode, a, b, input busy, done, result, cbout, ovf);
    modport slave (input start, mode, a, b, output busy, done, result, cbout, ovf);
endinterface

// File: rtl/bit_serial_addsub.sv
// bit_serial_addsub: LSB-first bit-serial add/subtract, one bit per clock.
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of bit_serial_addsub_if (start/mode/a/b in, busy/done/result/cbout/ovf out)
module bit_serial_addsub #(parameter int WIDTH = 8) (
    input logic                clk,
    input logic                rst_n,
    bit_serial_addsub_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] op_a, op_b, shreg, result;
    logic [IW-1:0] idx;
    logic op_mode, cb, cbout, ovf;
    logic ai, bi, s, cb_next, last;
    assign ai = op_a[idx];
    assign bi = op_b[idx];
    assign s = ai ^ bi ^ cb;
    // Same sum/difference bit; only the carry vs borrow propagation differs.
    assign cb_next = op_mode ? ((~ai & bi) | (~(ai ^ bi) & cb))
                             : ((ai & bi) | (ai & cb) | (bi & cb));
    assign last = idx == IW'(WIDTH - 1);
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.result = result;
    assign bus.cbout = cbout;
    assign bus.ovf = ovf;
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = bus.start ? RUN : IDLE;
            RUN: state_next = last ? DONE : RUN;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
            op_mode <= 1'b0;
            cb <= 1'b0;
            idx <= '0;
            shreg <= '0;
            result <= '0;
            cbout <= 1'b0;
            ovf <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            op_a <= bus.a;
            op_b <= bus.b;
            op_mode <= bus.mode;
            cb <= 1'b0;
            idx <= '0;
        end else if (state == RUN) begin
            // New bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
            shreg <= {s, shreg[WIDTH-1:1]};
            cb <= cb_next;
            idx <= idx + IW'(1);
            if (last) begin
                result <= {s, shreg[WIDTH-1:1]};
                cbout <= cb_next;
                // cb is still the carry/borrow into the MSB here.
                ovf <= cb ^ cb_next;
            end
        end
    end
endmodule

// File: tb/tb_bit_serial_addsub.sv
// tb_bit_serial_addsub: directed and randomized checks of bit_serial_addsub against an arithmetic model.
module tb_bit_serial_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int passed = 0;
    int total = 0;
    bit_serial_addsub_if #(.WIDTH(8)) bus ();
    bit_serial_addsub #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Returns {cbout, ovf, result} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic mode);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int u = mode ? ua - ub : ua + ub;
        int sv = mode ? sa - sb : sa + sb;
        logic c = mode ? (ua < ub) : (u > 255);
        logic o = (sv > 127) || (sv < -128);
        logic [7:0] r = 8'(u);
        return {c, o, r};
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic mode,
                          input logic [9:0] exp, input bit scramble, input bit poke);
        int edges = 0;
        int busy_n = 0;
        bit held = 1;
        logic [7:0] prev;
        prev = bus.result;
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.mode = mode;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        while (edges < 20) begin
            if (bus.done) break;
            if (bus.busy) busy_n++;
            if (bus.result !== prev) held = 0;
            if (scramble) begin
                bus.start = 1'($urandom);
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
                bus.mode = 1'($urandom);
            end
            @(negedge clk);
            edges++;
        end
        check({tag, ".latency"}, edges, 8);
        check({tag, ".busy_cycles"}, busy_n, 8);
        check({tag, ".held"}, held, 1);
        check({tag, ".busy_in_done"}, bus.busy, 0);
        check({tag, ".result"}, bus.result, exp[7:0]);
        check({tag, ".cbout"}, bus.cbout, exp[9]);
        check({tag, ".ovf"}, bus.ovf, exp[8]);
        if (poke) begin
            bus.start = 1'b1;
            bus.a = 8'hF0;
            bus.b = 8'hF0;
            bus.mode = 1'b0;
        end else begin
            bus.start = 1'b0;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".idle_after"}, {bus.busy, bus.done}, 0);
        check({tag, ".result_hold"}, bus.result, exp[7:0]);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic rm;
        bit saw_done;
        bus.start = 1'b1;
        bus.mode = 1'b0;
        bus.a = 8'h12;
        bus.b = 8'h34;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.done, 0);
        check("reset.result", bus.result, 0);
        check("reset.flags", {bus.cbout, bus.ovf}, 0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.busy", bus.busy, 0);
        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, {1'b0, 1'b1, 8'h8D}, 0, 0);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, {1'b1, 1'b0, 8'hF0}, 0, 0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, {1'b1, 1'b0, 8'h00}, 0, 0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, {1'b0, 1'b1, 8'h7F}, 0, 0);
        run_op("ignored_start", 8'h01, 8'h01, 1'b0, {1'b0, 1'b0, 8'h02}, 1, 1);
        run_op("back_to_back", 8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 8'h80}, 0, 0);
        // Reset while bit 3 would be processed.
        bus.start = 1'b1;
        bus.a = 8'h37;
        bus.b = 8'h11;
        bus.mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset.busy", bus.busy, 0);
        check("midreset.done", bus.done, 0);
        check("midreset.result", bus.result, 0);
        check("midreset.flags", {bus.cbout, bus.ovf}, 0);
        saw_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) saw_done = 1;
        end
        check("midreset.no_done", saw_done, 0);
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rm = 1'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, rm, model(ra, rb, rm), i % 2 == 1, 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
